// File: rtl/led_pwm_display.sv
// led_pwm_display: captures a data word and shows it on the LEDs with frame-synchronous PWM dimming.
// Define LED_PWM_FADE_EN to ramp the active brightness one step per frame instead of jumping to bright_i.

module led_pwm_display #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 100,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    data_i,
    input  logic                load_i,
    input  logic [PWM_BITS-1:0] bright_i,
    output logic [WIDTH-1:0]    led_o,
    output logic                frame_o,
    output logic                pending_o
);

    localparam int                  PS_W     = $clog2(PRESCALE);
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = '1;

    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                frame_q, frame_d;
    logic                pending_q, pending_d;
    logic [WIDTH-1:0]    pend_data_q, pend_data_d;
    logic [WIDTH-1:0]    disp_q, disp_d;
    logic [PWM_BITS-1:0] active_q, active_d;
    logic [WIDTH-1:0]    led_q, led_d;
    logic                tick;
    logic                frame_start;
    logic                led_on;

    always_comb begin
        tick        = (presc_q == PS_LAST);
        frame_start = tick && (pwm_q == PWM_LAST);
        presc_d     = tick ? '0 : presc_q + PS_W'(1);
        pwm_d       = tick ? pwm_q + PWM_BITS'(1) : pwm_q;
        frame_d     = frame_start;
    end

    // Display and brightness change only at the frame boundary; a load landing on it bypasses pending.
    always_comb begin
        pending_d   = pending_q;
        pend_data_d = pend_data_q;
        disp_d      = disp_q;
        active_d    = active_q;
        if (frame_start) begin
            pending_d = 1'b0;
            if (load_i) begin
                disp_d = data_i;
            end else if (pending_q) begin
                disp_d = pend_data_q;
            end
`ifdef LED_PWM_FADE_EN
            if (active_q < bright_i) begin
                active_d = active_q + PWM_BITS'(1);
            end else if (active_q > bright_i) begin
                active_d = active_q - PWM_BITS'(1);
            end
`else
            active_d = bright_i;
`endif
        end else if (load_i) begin
            pending_d   = 1'b1;
            pend_data_d = data_i;
        end
    end

    // All-ones brightness forces 100% duty, otherwise the top step of each frame would stay dark.
    always_comb begin
        led_on = (pwm_q < active_q) || (active_q == PWM_LAST);
        led_d  = led_on ? disp_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            pwm_q       <= '0;
            frame_q     <= 1'b0;
            pending_q   <= 1'b0;
            pend_data_q <= '0;
            disp_q      <= '0;
            active_q    <= '0;
            led_q       <= '0;
        end else begin
            presc_q     <= presc_d;
            pwm_q       <= pwm_d;
            frame_q     <= frame_d;
            pending_q   <= pending_d;
            pend_data_q <= pend_data_d;
            disp_q      <= disp_d;
            active_q    <= active_d;
            led_q       <= led_d;
        end
    end

    assign led_o     = led_q;
    assign frame_o   = frame_q;
    assign pending_o = pending_q;

endmodule

// File: doc/led_pwm_display.md
Name: led_pwm_display

Overview:
- Downstream consumer of the 8-bit free-running counter value; sits between the counter and the board LED pins, in the 100 MHz PLL clock domain.
- Captures a data word on request and displays it on the LEDs with global PWM brightness control.
- Updates only at PWM frame boundaries so the LEDs never glitch mid-frame.

Parameters:
- WIDTH, 8, number of LEDs / data bits
- PRESCALE, 100, clk cycles per PWM step (>=2)
- PWM_BITS, 4, PWM counter width; a frame is 2^PWM_BITS steps

Ports:
- clk  input  1  system clock (PLL output)
- rst_n  input  1  asynchronous active-low reset
- data_i  input  WIDTH  word to display (counter value)
- load_i  input  1  single-cycle strobe: capture data_i
- bright_i  input  PWM_BITS  target brightness, 0 = off, all-ones = fully on
- led_o  output  WIDTH  registered LED drive, 1 = lit
- frame_o  output  1  one-cycle pulse at each frame start
- pending_o  output  1  captured word waiting for next frame

Behaviour:
- Reset (async assert, sync release): led_o=0, frame_o=0, pending_o=0, prescaler=0, pwm_cnt=0, display register=0, pending register=0, active brightness=0.
- Prescaler counts 0..PRESCALE-1 and wraps. The step tick is asserted in the cycle where the prescaler equals PRESCALE-1.
- pwm_cnt increments on tick and wraps 2^PWM_BITS-1 -> 0. Frame start = tick while pwm_cnt == 2^PWM_BITS-1. frame_o is registered and is high in the cycle pwm_cnt becomes 0.
- Capture: on load_i, data_i is written to the pending register and pending_o=1 the next cycle. A second load_i before the frame boundary overwrites the pending word (last write wins).
- Frame boundary: if pending is set, pending -> display register and pending_o clears. bright_i is sampled into active brightness (non-fade build). All of this lands in the same cycle as frame_o=1.
- load_i coincident with the frame boundary: the new data_i goes directly to the display register, and pending_o stays/ends 0.
- LED on-condition: display bit = 1 AND (pwm_cnt < active brightness, OR active brightness == all-ones). All-ones gives 100% duty; 0 gives 0%. Duty otherwise = brightness/2^PWM_BITS.
- led_o is registered: 1-cycle latency from pwm_cnt/display change to pin.
- Latency load_i -> visible = up to one frame (PRESCALE*2^PWM_BITS cycles) + 1.
- bright_i changes mid-frame have no effect until the next boundary.
- Reset mid-frame: everything returns to reset values immediately. The first frame_o after release occurs PRESCALE*2^PWM_BITS cycles later.

Optional Feature:
- Macro: LED_PWM_FADE_EN.
- Defined: at each frame boundary, active brightness moves one step toward bright_i (+1 or -1, holds when equal). A 0 -> 15 transition therefore takes 15 frames.
- Undefined: active brightness loads bright_i directly at each frame boundary, and the fade logic is absent.

Test Plan (PRESCALE=4, PWM_BITS=4, WIDTH=8; frame = 64 cycles):
1. Reset, no load, bright_i=15 -> led_o=0x00 throughout. frame_o pulses every 64 cycles; first pulse at cycle 64 after release.
2. load_i with data_i=0xA5 mid-frame, bright_i=15 -> pending_o=1 until the next frame_o. In the same cycle as frame_o, pending_o clears. led_o=0xA5 one cycle later and stays constant.
3. data 0xFF, bright_i=4 -> per frame, led_o=0xFF for exactly 16 cycles (pwm_cnt 0..3) and 0x00 for 48 cycles. bright_i=0 -> led_o=0x00 all frame.
4. Two loads in one frame (0x11 then 0x22) -> only 0x22 is displayed; 0x11 never appears. Load coincident with frame boundary (0x3C) -> display=0x3C that boundary, pending_o stays 0.
5. Assert rst_n low for 3 cycles mid-frame with 0xA5 displayed -> led_o=0x00 and pending_o=0 asynchronously. Next frame_o comes 64 cycles after release.
6. LED_PWM_FADE_EN defined, display 0x01, bright_i stepped 0 -> 15 -> on-time of led_o[0] grows by 4 cycles per frame; reaches full-on after 15 frames. bright_i back to 0 decays symmetrically.
